// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Types and helpers shared by the calculator datapath blocks.
//   mult_state_t : control states of the sequential multiplier
//   cnt_width()  : width of an iteration counter that indexes 0..w-1
// ---------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Counter width for w iterations. Never returns 0, so a counter can always
    // be declared.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : calc_pkg

// File: rtl/full_adder_wcarry_nbits.sv
// ---------------------------------------------------------------------------
// full_adder_wcarry_nbits
// Combinational ripple-carry adder built from one full-adder cell per bit.
// Ports:
//   a_i    [width-1:0]  addend A
//   b_i    [width-1:0]  addend B
//   cin_i               carry into bit 0
//   sum_o  [width-1:0]  sum bits
//   cout_o              carry out of the top bit
// ---------------------------------------------------------------------------
module full_adder_wcarry_nbits #(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             cin_i,
    output logic [width-1:0] sum_o,
    output logic             cout_o
);

    logic [width:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < width; i++) begin : g_bit
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[width];

endmodule : full_adder_wcarry_nbits

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
// Sequential shift-and-add multiplier: one width-bit adder is reused over
// width cycles to form an unsigned width x width product.
// Ports:
//   clk_i              clock, rising edge
//   rst_ni             asynchronous active-low reset
//   start_i            start request, sampled only while idle
//   a_i   [width-1:0]  multiplicand, captured on an accepted start
//   b_i   [width-1:0]  multiplier, captured on an accepted start
//   busy_o             high while running or done
//   done_o             one-cycle completion pulse
//   p_o   [2*width-1:0] product, held until the next accepted start
// Build option:
//   MULT_ZERO_BYPASS_EN - a start with a zero operand goes straight to DONE
//                         (latency 1) instead of running all iterations.
// ---------------------------------------------------------------------------
module mult_seq_ctrl
    import calc_pkg::*;
#(
    parameter int width = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [width-1:0]   a_i,
    input  logic [width-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*width-1:0] p_o
);

    localparam int CNT_W = cnt_width(width);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width - 1);

    mult_state_t      state_q, state_d;
    logic [width-1:0] mcand_q, mcand_d;
    logic [width-1:0] acc_q,   acc_d;
    logic [width-1:0] q_q,     q_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [width-1:0] add_b;
    logic [width-1:0] add_sum;
    logic             add_cout;

    // Partial product for this iteration is the multiplicand gated by the
    // current low multiplier bit.
    assign add_b = q_q[0] ? mcand_q : '0;

    full_adder_wcarry_nbits #(
        .width (width)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d = a_i;
                    acc_d   = '0;
                    q_d     = b_i;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef MULT_ZERO_BYPASS_EN
                    if ((a_i == '0) || (b_i == '0)) begin
                        q_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end

            RUN: begin
                // {cout, sum, q} >> 1: the consumed multiplier bit drops off
                // the bottom while the new sum bit shifts into q.
                {acc_d, q_d} = {add_cout, add_sum, q_q[width-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign p_o    = {acc_q, q_q};

endmodule : mult_seq_ctrl

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    localparam int W  = 8;
    localparam int PW = 2 * W;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [PW-1:0] p_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mult_seq_ctrl #(.width(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .p_o     (p_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    // Reference model: an operation is "active" for len cycles after the
    // accepting edge, done in its last cycle, and its result is a*b.
    bit            m_active = 1'b0;
    int            m_t      = 0;
    int            m_len    = 0;
    logic [PW-1:0] m_p      = '0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_active = 1'b0;
            m_t      = 0;
            m_len    = 0;
            m_p      = '0;
        end else if (m_active) begin
            m_t++;
            if (m_t > m_len) m_active = 1'b0;
        end else if (start_i) begin
            m_active = 1'b1;
            m_t      = 1;
            m_len    = (BYP && (a_i == 0 || b_i == 0)) ? 1 : W + 1;
            m_p      = PW'(a_i) * PW'(b_i);
        end
    end

    // Every-cycle comparison against the model; the product is only
    // meaningful when idle or done.
    always @(negedge clk_i) begin
        total++;
        if (busy_o !== m_active) begin
            bad++;
            $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy_o, m_active);
        end
        total++;
        if (done_o !== (m_active && m_t == m_len)) begin
            bad++;
            $display("FAIL model_done cyc=%0d got=%b exp=%b", cyc, done_o, (m_active && m_t == m_len));
        end
        if (!m_active || m_t == m_len) begin
            total++;
            if (p_o !== m_p) begin
                bad++;
                $display("FAIL model_p cyc=%0d got=%h exp=%h", cyc, p_o, m_p);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Start one op from idle, wait for done, check latency and product.
    // Returns at the negedge of the done cycle; acc_cyc is the accept edge.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_p, input int exp_lat, input string name,
                          output int acc_cyc);
        int n;
        @(posedge clk_i); #1;
        start_i = 1'b1; a_i = a; b_i = b;
        @(posedge clk_i);
        acc_cyc = cyc;
        #1 start_i = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge clk_i);
            n++;
            if (done_o) break;
        end
        if (!done_o) begin
            bad++; total++;
            $display("FAIL %s_timeout got=no_done exp=done", name);
        end else begin
            check({name, "_lat"}, n, exp_lat);
            check({name, "_p"}, p_o, exp_p);
        end
    endtask

    initial begin
        int c0, c1, dc, dcyc;

        // Reset values
        @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_p", p_o, 0);
        #2 rst_ni = 1'b1;

        do_mul(8'd13, 8'd11, 143, 9, "m13x11", c0);
        do_mul(8'd255, 8'd255, 16'hFE01, 9, "m255x255", c0);
        do_mul(8'd0, 8'd200, 0, BYP ? 1 : 9, "m0x200", c0);

        // Start pulses in cycles 3 and 9 of a 6x7 must be ignored.
        @(posedge clk_i); #1;
        start_i = 1'b1; a_i = 8'd6; b_i = 8'd7;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        dc = 0; dcyc = 0;
        for (int c = 1; c <= 14; c++) begin
            start_i = (c == 3 || c == 9);
            @(negedge clk_i);
            if (done_o) begin dc++; dcyc = c; end
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        check("ign_done_cnt", dc, 1);
        check("ign_done_cyc", dcyc, 9);
        check("ign_p", p_o, 42);

        // Reset asserted in cycle 4 of 100x3
        @(posedge clk_i); #1;
        start_i = 1'b1; a_i = 8'd100; b_i = 8'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check("mrst_busy", busy_o, 0);
        check("mrst_done", done_o, 0);
        check("mrst_p", p_o, 0);
        @(negedge clk_i); #1 rst_ni = 1'b1;
        do_mul(8'd100, 8'd3, 300, 9, "m100x3", c0);

        // Back-to-back: second start on the first idle cycle
        do_mul(8'd2, 8'd3, 6, 9, "bb1", c0);
        do_mul(8'd4, 8'd5, 20, 9, "bb2", c1);
        check("bb_spacing", c1 - c0, 10);

        // Random traffic with random start spam, checked by the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i); #1;
            start_i = ($urandom_range(0, 3) != 0);
            a_i = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            b_i = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
        end
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (12) @(posedge clk_i);
        @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult_seq_ctrl
